uart_txrx: RTL and testbench
============================

Name: uart_txrx

Overview:
- Full-duplex 8N1 UART: a byte-stream transmitter (valid/ready in, serial out) and a byte-stream receiver (serial in, valid/ready out) in one block.
- Both paths share one clock and one bit-timing parameter.
- The RX path buffers received bytes in a FIFO, so a consumer can drain several frames after they have arrived.
- Sits between a byte-oriented core and the board UART pins; txd looped to rxd is the reference self-test configuration.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range ≥ 4.
- RX_FIFO_DEPTH, 8, received-byte buffer entries; power of two, ≥ 2.

Ports:
- clk  in  1  single system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  transmitter can accept a byte.
- txd  out  1  serial output; idle high.
- rxd  in  1  serial input; asynchronous to clk.
- rx_data  out  8  oldest received byte (FIFO head).
- rx_valid  out  1  RX FIFO non-empty.
- rx_ready  in  1  consumer accepts rx_data.
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- rx_overflow  out  1  one-cycle pulse: byte dropped, FIFO full.

Behaviour:
- Frame format: start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity. Each bit lasts exactly CLKS_PER_BIT cycles.
- Handshakes: a transfer occurs on a rising clk edge with valid && ready. Once asserted, valid must not drop, and data must not change, until the transfer. The block itself obeys this rule on rx_valid/rx_data.
- Reset state (async assert, sync deassert): txd=1, tx_ready=1, rx_valid=0, rx_frame_err=0, rx_overflow=0, RX FIFO empty. rx_data is don't-care while rx_valid=0. Reset mid-frame aborts the frame; txd returns high immediately.
- TX states and transitions:
  - IDLE: tx_ready=1, txd=1. On a transfer, latch tx_data into a shift register and go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, beginning the cycle after acceptance.
  - DATA: bits 0..7 shifted out LSB first, CLKS_PER_BIT cycles each.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then IDLE.
  - tx_ready=0 in START, DATA and STOP. Minimum spacing between accepts is 10*CLKS_PER_BIT+1 cycles.
  - txd is driven from a flop (glitch-free).
- RX input: rxd passes through a 2-flop synchronizer, reset to 1.
- RX states and transitions:
  - IDLE: on synchronized rxd=0, go to START.
  - START: at CLKS_PER_BIT/2 re-sample. If 1, it is a glitch: return to IDLE. If 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles thereafter, 8 samples, shifted in LSB first.
  - STOP: sample one more bit period later.
    - Stop = 1: push the byte into the FIFO.
    - Stop = 0: discard the byte, pulse rx_frame_err, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxd=1, then IDLE.
  - After the stop sample, return to IDLE immediately, so back-to-back frames are received.
- RX FIFO:
  - Push at the mid-stop sample; rx_valid rises the following cycle.
  - Pop on rx_valid && rx_ready.
  - rx_data = FIFO head, registered or comb-read from storage, stable until popped.
  - Push and pop in the same cycle are both honoured, and the count is unchanged.
  - Push when full and no pop that cycle: the new byte is dropped, rx_overflow pulses, and FIFO contents are intact.
  - Pointers wrap modulo RX_FIFO_DEPTH. An extra pointer bit distinguishes full from empty.
- TX and RX are fully independent; simultaneous activity is required to work.

Decomposition:
- uart_pkg:
  - DATA_BITS=8 and the frame-length constant.
  - tx_state_t enum: IDLE, START, DATA, STOP.
  - rx_state_t enum: IDLE, START, DATA, STOP, WAIT_IDLE.
- Sub-module uart_byte_fifo (parameter DEPTH): synchronous FIFO with push/full and pop/empty, plus head output.
- The TX and RX FSMs and the bit-period counters stay in uart_txrx.

Test Plan:
- Reset release, txd looped to rxd, CLKS_PER_BIT=8 → rx_valid=0 and tx_ready=1 one cycle after reset deasserts.
- Burst and drain: send 8'hFE, ED, DC, CB, BA, A9, 98, 87 back-to-back with rx_ready=0, then drain with rx_ready=1 → bytes received in that order. Afterwards rx_valid=0, tx_ready=1, no overflow or framing-error pulses.
- Serial timing: send 8'hA5 and check txd → low for 8 cycles, then bits 1,0,1,0,0,1,0,1 for 8 cycles each, then high. tx_ready returns after 80 cycles.
- Overflow: with rx_ready=0, send 9 bytes 8'h01..8'h09 → rx_overflow pulses once at the 9th stop sample; drain yields 01..08.
- Framing error: drive rxd externally with a frame of 8'h3C whose stop bit is 0 → rx_frame_err pulses and no push occurs. A following valid frame of 8'h55 is received correctly.
- Start glitch and mid-frame reset:
  - rxd low for 2 cycles → no reception.
  - Assert rst mid-TX frame → txd=1 and tx_ready=1 immediately; the RX FIFO is emptied.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the uart_txrx block.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 1 + DATA_BITS + 1;
    localparam int BIT_IDX_W  = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with a comb-read head; an extra pointer bit separates full from empty.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop,
    output logic                 full,
    output logic                 empty,
    output logic [DATA_BITS-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer advance; a push into a full FIFO is only honoured when a pop frees the slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART: valid/ready byte transmitter and FIFO-buffered receiver.
module uart_txrx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 434,
    parameter int RX_FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_overflow
);

    localparam int                 CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]      CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]      CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_IDX_W-1:0] BIT_LAST = BIT_IDX_W'(DATA_BITS - 1);

    tx_state_t              tx_state, tx_state_n;
    logic [CW-1:0]          tx_cnt, tx_cnt_n;
    logic [BIT_IDX_W-1:0]   tx_bit, tx_bit_n;
    logic [DATA_BITS-1:0]   tx_shift, tx_shift_n;
    logic                   txd_q, txd_n;

    rx_state_t              rx_state, rx_state_n;
    logic [CW-1:0]          rx_cnt, rx_cnt_n;
    logic [BIT_IDX_W-1:0]   rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0]   rx_shift, rx_shift_n;
    logic                   rxd_meta, rxd_sync;
    logic                   rx_push, frame_err_n;
    logic                   rx_pop, fifo_full, fifo_empty;

    assign txd      = txd_q;
    assign tx_ready = (tx_state == TX_IDLE);

    // TX state register; txd comes straight from a flop so the pin never glitches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            txd_q    <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            txd_q    <= txd_n;
        end
    end

    // TX next state: txd_n is the level for the coming cycle, so each bit lasts exactly one period
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        txd_n      = txd_q;
        case (tx_state)
            TX_IDLE: begin
                txd_n = 1'b1;
                if (tx_valid) begin
                    tx_shift_n = tx_data;
                    tx_cnt_n   = '0;
                    tx_state_n = TX_START;
                    txd_n      = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = TX_DATA;
                    txd_n      = tx_shift[0];
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_bit == BIT_LAST) begin
                        tx_state_n = TX_STOP;
                        txd_n      = 1'b1;
                    end else begin
                        tx_bit_n   = tx_bit + 1'b1;
                        tx_shift_n = tx_shift >> 1;
                        txd_n      = tx_shift[1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_IDLE;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            default: begin
                tx_state_n = TX_IDLE;
                txd_n      = 1'b1;
            end
        endcase
    end

    // Two-flop synchronizer for the asynchronous serial input, idling high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
        end
    end

    // RX state register plus registered status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_frame_err <= 1'b0;
            rx_overflow  <= 1'b0;
        end else begin
            rx_state     <= rx_state_n;
            rx_cnt       <= rx_cnt_n;
            rx_bit       <= rx_bit_n;
            rx_shift     <= rx_shift_n;
            rx_frame_err <= frame_err_n;
            rx_overflow  <= rx_push && fifo_full && !rx_pop;
        end
    end

    // RX next state: find the start-bit middle, then sample once per bit period
    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt;
        rx_bit_n    = rx_bit;
        rx_shift_n  = rx_shift;
        rx_push     = 1'b0;
        frame_err_n = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rxd_sync) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt == CNT_HALF) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rxd_sync ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == CNT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rxd_sync, rx_shift[DATA_BITS-1:1]};
                    if (rx_bit == BIT_LAST) begin
                        rx_state_n = RX_STOP;
                    end else begin
                        rx_bit_n = rx_bit + 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == CNT_LAST) begin
                    rx_cnt_n = '0;
                    if (rxd_sync) begin
                        rx_push    = 1'b1;
                        rx_state_n = RX_IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        rx_state_n  = RX_WAIT_IDLE;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_WAIT_IDLE: begin
                if (rxd_sync) rx_state_n = RX_IDLE;
            end
            default: begin
                rx_state_n = RX_IDLE;
            end
        endcase
    end

    assign rx_valid = !fifo_empty;
    assign rx_pop   = rx_valid && rx_ready;

    uart_byte_fifo #(
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (rx_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (rx_data)
    );

endmodule

// File: tb/tb_uart_txrx.sv
// Directed bench for uart_txrx with txd looped to rxd and an external rxd override.
module tb_uart_txrx;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       txd;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_frame_err;
    logic       rx_overflow;

    logic       ext_drive = 1'b0;
    logic       ext_rxd = 1'b1;

    int assert_count = 0;
    int fail_count = 0;
    int ovf_pulses = 0;
    int ferr_pulses = 0;

    logic [7:0] burst [8];
    logic [9:0] frame;

    assign rxd = ext_drive ? ext_rxd : txd;

    uart_txrx #(
        .CLKS_PER_BIT  (CPB),
        .RX_FIFO_DEPTH (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .txd          (txd),
        .rxd          (rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_overflow  (rx_overflow)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // Tally status pulses so every pulse is seen regardless of the step in progress
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_overflow)  ovf_pulses  <= ovf_pulses + 1;
            if (rx_frame_err) ferr_pulses <= ferr_pulses + 1;
        end
    end

    // Hard stop if something stalls beyond any legitimate run length
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Send one byte through the transmitter; returns at the negedge just after acceptance
    task automatic applyStimulus(input logic [7:0] b);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) checkOutput("tx_ready_timeout", 32'(tx_ready), 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Wait until the transmitter is idle and the looped-back frame has settled in RX
    task automatic waitTxIdle();
        int n = 0;
        while (tx_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) checkOutput("tx_idle_timeout", 32'(tx_ready), 32'd1);
        repeat (20) @(negedge clk);
    endtask

    // Check the FIFO head and pop it with a one-cycle rx_ready
    task automatic popCheck(input string tag, input logic [7:0] expected);
        checkOutput({tag, "_valid"}, 32'(rx_valid), 32'd1);
        checkOutput({tag, "_data"}, 32'(rx_data), 32'(expected));
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    // Bit-bang one frame on rxd with a chosen stop level, then idle high
    task automatic driveFrame(input logic [7:0] b, input logic stop_bit);
        ext_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ext_rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        ext_rxd = stop_bit;
        repeat (CPB) @(negedge clk);
        ext_rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    initial begin
        burst[0] = 8'hFE; burst[1] = 8'hED; burst[2] = 8'hDC; burst[3] = 8'hCB;
        burst[4] = 8'hBA; burst[5] = 8'hA9; burst[6] = 8'h98; burst[7] = 8'h87;

        // Reset release
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset_tx_ready", 32'(tx_ready), 32'd1);
        checkOutput("reset_txd", 32'(txd), 32'd1);
        checkOutput("reset_frame_err", 32'(rx_frame_err), 32'd0);
        checkOutput("reset_overflow", 32'(rx_overflow), 32'd0);

        // Burst of eight frames into the FIFO, then drain in order
        for (int i = 0; i < 8; i++) applyStimulus(burst[i]);
        waitTxIdle();
        for (int i = 0; i < 8; i++) popCheck($sformatf("burst%0d", i), burst[i]);
        checkOutput("burst_empty", 32'(rx_valid), 32'd0);
        checkOutput("burst_tx_ready", 32'(tx_ready), 32'd1);
        checkOutput("burst_ovf", 32'(ovf_pulses), 32'd0);
        checkOutput("burst_ferr", 32'(ferr_pulses), 32'd0);

        // Exact serial waveform of 8'hA5: start, LSB-first data, stop
        frame = {1'b1, 8'hA5, 1'b0};
        applyStimulus(8'hA5);
        for (int i = 0; i < 10 * CPB; i++) begin
            checkOutput($sformatf("a5_txd_c%0d", i), 32'(txd), 32'(frame[i / CPB]));
            if (i == 0 || i == 10 * CPB - 1)
                checkOutput($sformatf("a5_busy_c%0d", i), 32'(tx_ready), 32'd0);
            @(negedge clk);
        end
        checkOutput("a5_ready_back", 32'(tx_ready), 32'd1);
        checkOutput("a5_txd_idle", 32'(txd), 32'd1);
        repeat (20) @(negedge clk);
        popCheck("a5_rx", 8'hA5);

        // Overflow: nine frames into an eight-entry FIFO
        for (int i = 1; i <= 9; i++) applyStimulus(8'(i));
        waitTxIdle();
        checkOutput("ovf_pulses", 32'(ovf_pulses), 32'd1);
        for (int i = 1; i <= 8; i++) popCheck($sformatf("ovf%0d", i), 8'(i));
        checkOutput("ovf_empty", 32'(rx_valid), 32'd0);

        // Framing error then a clean frame
        ext_drive = 1'b1;
        driveFrame(8'h3C, 1'b0);
        checkOutput("ferr_pulses", 32'(ferr_pulses), 32'd1);
        checkOutput("ferr_no_push", 32'(rx_valid), 32'd0);
        driveFrame(8'h55, 1'b1);
        checkOutput("ferr_after_count", 32'(ferr_pulses), 32'd1);
        popCheck("after_ferr", 8'h55);
        checkOutput("after_ferr_empty", 32'(rx_valid), 32'd0);

        // Short start glitch must not start a reception
        ext_rxd = 1'b0;
        repeat (2) @(negedge clk);
        ext_rxd = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        checkOutput("glitch_no_rx", 32'(rx_valid), 32'd0);
        checkOutput("glitch_no_ferr", 32'(ferr_pulses), 32'd1);
        ext_drive = 1'b0;

        // Reset in the middle of a TX frame with a byte already buffered
        applyStimulus(8'h77);
        waitTxIdle();
        checkOutput("rst_prefill", 32'(rx_valid), 32'd1);
        applyStimulus(8'h12);
        repeat (29) @(negedge clk);
        checkOutput("rst_mid_txd", 32'(txd), 32'd0);
        checkOutput("rst_mid_busy", 32'(tx_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_txd", 32'(txd), 32'd1);
        checkOutput("rst_async_ready", 32'(tx_ready), 32'd1);
        checkOutput("rst_async_empty", 32'(rx_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        checkOutput("rst_after_txd", 32'(txd), 32'd1);
        checkOutput("rst_after_ready", 32'(tx_ready), 32'd1);
        checkOutput("rst_after_empty", 32'(rx_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
